// File: rtl/kbd_spi_matrix.sv
// kbd_spi_matrix: receives the keyboard matrix over a slave SPI link from the
// PS/2 controller and presents it to the CPU as port FE column data.
//
// Build option: define KBD_JOY_EN to extend the frame to 45 bits. The last
// five bits received are then latched onto the JOY output (Kempston R,L,D,U,F).
// Without it, frames are 40 bits and a 45-bit frame is rejected.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a KBD_CS falling edge to start a frame
// SHIFT  | frame in progress, sampling KBD_DI on KBD_CLK rising edges
// ABORT  | watchdog expired, ignoring KBD_CLK until KBD_CS rises
`timescale 1ns/1ps

module kbd_spi_matrix #(
    parameter int TIMEOUT_W = 16
) (
    input  logic        CLK_14MHZ,
    input  logic        CPU_RESET,
    input  logic        KBD_CLK,
    input  logic        KBD_CS,
    input  logic        KBD_DI,
    input  logic [7:0]  A_HI,
    output logic [4:0]  KB,
    output logic        FRAME_OK,
    output logic [3:0]  ERR_CNT
`ifdef KBD_JOY_EN
    ,
    output logic [4:0]  JOY
`endif
);

`ifdef KBD_JOY_EN
    localparam int FRAME_BITS = 45;
`else
    localparam int FRAME_BITS = 40;
`endif
    localparam int          MATRIX_BITS  = 40;
    localparam logic [5:0]  FRAME_BITS_C = 6'(FRAME_BITS);
    localparam logic [5:0]  BIT_CNT_MAX  = 6'd63;
    localparam logic [3:0]  ERR_CNT_MAX  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_clk_s1, r_clk_s2, r_clk_d;
    logic r_cs_s1, r_cs_s2, r_cs_d;
    logic r_di_s1, r_di_s2;
    logic [2:0] r_sync_vld;
    logic r_cs_armed;

    logic w_clk_rise;
    logic w_cs_rise;
    logic w_cs_fall;

    logic w_start;
    logic w_shift_en;
    logic w_commit;
    logic w_err;

    logic [5:0]             r_bit_cnt;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [MATRIX_BITS-1:0] r_matrix;
    logic                   r_frame_ok;
    logic [3:0]             r_err_cnt;
    logic [4:0]             w_col_or;
`ifdef KBD_JOY_EN
    logic [4:0]             r_joy;
`endif

    // Two-flop synchronisers plus one edge-detect stage for the SPI inputs.
    // r_sync_vld marks when the chain holds real samples rather than reset
    // values; a CS falling edge is only honoured after CS has genuinely been
    // seen high, so a frame cut by reset cannot restart mid-stream.
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_d    <= 1'b0;
            r_cs_s1    <= 1'b1;
            r_cs_s2    <= 1'b1;
            r_cs_d     <= 1'b1;
            r_di_s1    <= 1'b0;
            r_di_s2    <= 1'b0;
            r_sync_vld <= 3'b000;
            r_cs_armed <= 1'b0;
        end else begin
            r_clk_s1   <= KBD_CLK;
            r_clk_s2   <= r_clk_s1;
            r_clk_d    <= r_clk_s2;
            r_cs_s1    <= KBD_CS;
            r_cs_s2    <= r_cs_s1;
            r_cs_d     <= r_cs_s2;
            r_di_s1    <= KBD_DI;
            r_di_s2    <= r_di_s1;
            r_sync_vld <= {r_sync_vld[1:0], 1'b1};
            if (r_sync_vld[2] && r_cs_s2) begin
                r_cs_armed <= 1'b1;
            end
        end
    end

    assign w_clk_rise = r_clk_s2 & ~r_clk_d;
    assign w_cs_rise  = r_cs_s2 & ~r_cs_d;
    assign w_cs_fall  = r_cs_armed & r_cs_d & ~r_cs_s2;

    // FSM state register.
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and datapath strobes; frame end takes priority over
    // the watchdog, and the watchdog over a coincident data clock.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_start     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    if (r_bit_cnt == FRAME_BITS_C) begin
                        w_commit = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (r_wdog == '1) begin
                    w_state_nxt = ST_ABORT;
                    w_err       = 1'b1;
                end else if (w_clk_rise) begin
                    w_shift_en = 1'b1;
                end
            end
            ST_ABORT: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register, saturating bit counter and CS-low watchdog.
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_wdog    <= '0;
        end else begin
            if (w_start) begin
                r_bit_cnt <= '0;
                r_wdog    <= '0;
            end else begin
                if (r_state == ST_SHIFT) begin
                    r_wdog <= r_wdog + TIMEOUT_W'(1);
                end
                if (w_shift_en) begin
                    r_shift <= {r_shift[FRAME_BITS-2:0], r_di_s2};
                    if (r_bit_cnt != BIT_CNT_MAX) begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
            end
        end
    end

    // Commit a complete frame in one clock so KB never sees partial data.
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            r_matrix   <= '0;
            r_frame_ok <= 1'b0;
`ifdef KBD_JOY_EN
            r_joy      <= '0;
`endif
        end else begin
            r_frame_ok <= w_commit;
            if (w_commit) begin
                r_matrix <= r_shift[FRAME_BITS-1 -: MATRIX_BITS];
`ifdef KBD_JOY_EN
                r_joy    <= r_shift[4:0];
`endif
            end
        end
    end

    // Saturating count of rejected or timed-out frames.
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != ERR_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 4'd1;
        end
    end

    // Port FE column read: OR the columns of every selected (low) row.
    always_comb begin
        w_col_or = 5'b00000;
        for (int row = 0; row < 8; row++) begin
            if (!A_HI[row]) begin
                w_col_or = w_col_or | r_matrix[5*row +: 5];
            end
        end
    end

    assign KB       = ~w_col_or;
    assign FRAME_OK = r_frame_ok;
    assign ERR_CNT  = r_err_cnt;
`ifdef KBD_JOY_EN
    assign JOY      = r_joy;
`endif

endmodule

// File: tb/tb_kbd_spi_matrix.sv
// Directed testbench for kbd_spi_matrix; follows KBD_JOY_EN like the design.
`timescale 1ns/1ps

module tb_kbd_spi_matrix;

`ifdef KBD_JOY_EN
    localparam int FB = 45;
`else
    localparam int FB = 40;
`endif

    logic       CLK_14MHZ = 1'b0;
    logic       CPU_RESET = 1'b0;
    logic       KBD_CLK   = 1'b0;
    logic       KBD_CS    = 1'b1;
    logic       KBD_DI    = 1'b0;
    logic [7:0] A_HI      = 8'h00;
    logic [4:0] KB;
    logic       FRAME_OK;
    logic [3:0] ERR_CNT;
`ifdef KBD_JOY_EN
    logic [4:0] JOY;
`endif

    int n_cmp   = 0;
    int n_bad   = 0;
    int ok_cnt  = 0;
    int ok_wide = 0;
    int exp_err = 0;
    logic ok_prev = 1'b0;

    kbd_spi_matrix dut (
        .CLK_14MHZ (CLK_14MHZ),
        .CPU_RESET (CPU_RESET),
        .KBD_CLK   (KBD_CLK),
        .KBD_CS    (KBD_CS),
        .KBD_DI    (KBD_DI),
        .A_HI      (A_HI),
        .KB        (KB),
        .FRAME_OK  (FRAME_OK),
        .ERR_CNT   (ERR_CNT)
`ifdef KBD_JOY_EN
        ,
        .JOY       (JOY)
`endif
    );

    always #5 CLK_14MHZ = ~CLK_14MHZ;

    always @(negedge CLK_14MHZ) begin
        if (FRAME_OK === 1'b1) ok_cnt++;
        if (FRAME_OK === 1'b1 && ok_prev === 1'b1) ok_wide++;
        ok_prev = FRAME_OK;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge CLK_14MHZ);
        #2;
    endtask

    function automatic logic [127:0] mkf(input logic [39:0] m, input logic [4:0] j);
`ifdef KBD_JOY_EN
        return {83'd0, m, j};
`else
        return {88'd0, m} | {123'd0, j & 5'b00000};
`endif
    endfunction

    task automatic send_bits(input logic [127:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            KBD_DI = v[n-1-k];
            clks(4);
            KBD_CLK = 1'b1;
            clks(4);
            KBD_CLK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [127:0] v, input int n, input int tail);
        KBD_CS = 1'b0;
        clks(4);
        send_bits(v, n);
        clks(4);
        KBD_CS = 1'b1;
        clks(tail);
    endtask

    task automatic test_reset;
        CPU_RESET = 1'b0;
        A_HI = 8'h00;
        clks(3);
        n_cmp++; if (KB !== 5'h1F) begin n_bad++; $display("FAIL reset_kb: got %b want %b", KB, 5'h1F); end
        n_cmp++; if (ERR_CNT !== 4'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", ERR_CNT); end
        n_cmp++; if (FRAME_OK !== 1'b0) begin n_bad++; $display("FAIL reset_frame_ok: got %b want 0", FRAME_OK); end
`ifdef KBD_JOY_EN
        n_cmp++; if (JOY !== 5'd0) begin n_bad++; $display("FAIL reset_joy: got %b want 00000", JOY); end
`endif
        CPU_RESET = 1'b1;
        clks(6);
    endtask

    task automatic test_single_key;
        logic [7:0] a_tab [4] = '{8'hFE, 8'hFD, 8'h00, 8'hFF};
        logic [4:0] e_tab [4] = '{5'h1E, 5'h1F, 5'h1E, 5'h1F};
        ok_cnt = 0;
        send_frame(mkf(40'd1, 5'd0), FB, 8);
        for (int i = 0; i < 4; i++) begin
            A_HI = a_tab[i]; #1;
            n_cmp++; if (KB !== e_tab[i]) begin n_bad++; $display("FAIL single_key a_hi=%h: got %b want %b", a_tab[i], KB, e_tab[i]); end
        end
        n_cmp++; if (ok_cnt != 1) begin n_bad++; $display("FAIL single_key_frame_ok: got %0d pulses want 1", ok_cnt); end
        n_cmp++; if (ERR_CNT !== 4'(exp_err)) begin n_bad++; $display("FAIL single_key_err: got %0d want %0d", ERR_CNT, exp_err); end
    endtask

    task automatic test_multi_key;
        logic [7:0] a_tab [6] = '{8'hF7, 8'h7F, 8'hFE, 8'h76, 8'hFF, 8'hEF};
        logic [4:0] e_tab [6] = '{5'h1B, 5'h0F, 5'h1D, 5'h09, 5'h1F, 5'h1F};
        ok_cnt = 0;
        send_frame(mkf(40'h80_0002_0002, 5'd0), FB, 8);
        for (int i = 0; i < 6; i++) begin
            A_HI = a_tab[i]; #1;
            n_cmp++; if (KB !== e_tab[i]) begin n_bad++; $display("FAIL multi_key a_hi=%h: got %b want %b", a_tab[i], KB, e_tab[i]); end
        end
        n_cmp++; if (ok_cnt != 1) begin n_bad++; $display("FAIL multi_key_frame_ok: got %0d pulses want 1", ok_cnt); end
    endtask

    task automatic test_short_frame;
        ok_cnt = 0;
        send_frame({128{1'b1}}, FB - 1, 8);
        exp_err++;
        A_HI = 8'h76; #1;
        n_cmp++; if (KB !== 5'h09) begin n_bad++; $display("FAIL short_frame_kb: got %b want %b", KB, 5'h09); end
        n_cmp++; if (ERR_CNT !== 4'(exp_err)) begin n_bad++; $display("FAIL short_frame_err: got %0d want %0d", ERR_CNT, exp_err); end
        n_cmp++; if (ok_cnt != 0) begin n_bad++; $display("FAIL short_frame_frame_ok: got %0d pulses want 0", ok_cnt); end
    endtask

`ifdef KBD_JOY_EN
    task automatic test_joy;
        ok_cnt = 0;
        send_frame(mkf(40'h80_0002_0002, 5'b00001), FB, 8);
        n_cmp++; if (JOY !== 5'b00001) begin n_bad++; $display("FAIL joy_value: got %b want 00001", JOY); end
        A_HI = 8'h76; #1;
        n_cmp++; if (KB !== 5'h09) begin n_bad++; $display("FAIL joy_kb: got %b want %b", KB, 5'h09); end
        n_cmp++; if (ok_cnt != 1) begin n_bad++; $display("FAIL joy_frame_ok: got %0d pulses want 1", ok_cnt); end
    endtask
`else
    task automatic test_long_frame;
        ok_cnt = 0;
        send_frame({128{1'b1}}, 45, 8);
        exp_err++;
        A_HI = 8'h76; #1;
        n_cmp++; if (KB !== 5'h09) begin n_bad++; $display("FAIL long_frame_kb: got %b want %b", KB, 5'h09); end
        n_cmp++; if (ERR_CNT !== 4'(exp_err)) begin n_bad++; $display("FAIL long_frame_err: got %0d want %0d", ERR_CNT, exp_err); end
        n_cmp++; if (ok_cnt != 0) begin n_bad++; $display("FAIL long_frame_frame_ok: got %0d pulses want 0", ok_cnt); end
    endtask
`endif

    // 64 extra bits would bring a wrapping counter back to exactly FB.
    task automatic test_bitcnt_saturation;
        ok_cnt = 0;
        send_frame(128'd0, 64 + FB, 8);
        exp_err++;
        A_HI = 8'h76; #1;
        n_cmp++; if (KB !== 5'h09) begin n_bad++; $display("FAIL bitcnt_sat_kb: got %b want %b", KB, 5'h09); end
        n_cmp++; if (ERR_CNT !== 4'(exp_err)) begin n_bad++; $display("FAIL bitcnt_sat_err: got %0d want %0d", ERR_CNT, exp_err); end
        n_cmp++; if (ok_cnt != 0) begin n_bad++; $display("FAIL bitcnt_sat_frame_ok: got %0d pulses want 0", ok_cnt); end
    endtask

    task automatic test_timeout;
        ok_cnt = 0;
        KBD_CS = 1'b0;
        clks(65000);
        n_cmp++; if (ERR_CNT !== 4'(exp_err)) begin n_bad++; $display("FAIL timeout_early: got %0d want %0d", ERR_CNT, exp_err); end
        clks(700);
        exp_err++;
        n_cmp++; if (ERR_CNT !== 4'(exp_err)) begin n_bad++; $display("FAIL timeout_err: got %0d want %0d", ERR_CNT, exp_err); end
        send_bits({128{1'b1}}, 5);
        clks(4);
        KBD_CS = 1'b1;
        clks(8);
        n_cmp++; if (ERR_CNT !== 4'(exp_err)) begin n_bad++; $display("FAIL timeout_abort_err: got %0d want %0d", ERR_CNT, exp_err); end
        n_cmp++; if (ok_cnt != 0) begin n_bad++; $display("FAIL timeout_abort_frame_ok: got %0d pulses want 0", ok_cnt); end
        A_HI = 8'h76; #1;
        n_cmp++; if (KB !== 5'h09) begin n_bad++; $display("FAIL timeout_abort_kb: got %b want %b", KB, 5'h09); end
        send_frame(mkf(40'd1, 5'd0), FB, 8);
        A_HI = 8'h76; #1;
        n_cmp++; if (KB !== 5'h1E) begin n_bad++; $display("FAIL timeout_next_kb: got %b want %b", KB, 5'h1E); end
        n_cmp++; if (ok_cnt != 1) begin n_bad++; $display("FAIL timeout_next_frame_ok: got %0d pulses want 1", ok_cnt); end
    endtask

    task automatic test_reset_mid_frame;
        ok_cnt = 0;
        KBD_CS = 1'b0;
        clks(4);
        send_bits({128{1'b1}}, 20);
        CPU_RESET = 1'b0;
        A_HI = 8'h00;
        clks(2);
        exp_err = 0;
        n_cmp++; if (KB !== 5'h1F) begin n_bad++; $display("FAIL midreset_kb: got %b want %b", KB, 5'h1F); end
        n_cmp++; if (ERR_CNT !== 4'd0) begin n_bad++; $display("FAIL midreset_err: got %0d want 0", ERR_CNT); end
`ifdef KBD_JOY_EN
        n_cmp++; if (JOY !== 5'd0) begin n_bad++; $display("FAIL midreset_joy: got %b want 00000", JOY); end
`endif
        CPU_RESET = 1'b1;
        clks(10);
        KBD_CS = 1'b1;
        clks(8);
        n_cmp++; if (ERR_CNT !== 4'd0) begin n_bad++; $display("FAIL midreset_stale_err: got %0d want 0", ERR_CNT); end
        n_cmp++; if (KB !== 5'h1F) begin n_bad++; $display("FAIL midreset_stale_kb: got %b want %b", KB, 5'h1F); end
        send_frame(mkf(40'h80_0002_0002, 5'd0), FB, 8);
        A_HI = 8'h76; #1;
        n_cmp++; if (KB !== 5'h09) begin n_bad++; $display("FAIL midreset_new_kb: got %b want %b", KB, 5'h09); end
        n_cmp++; if (ok_cnt != 1) begin n_bad++; $display("FAIL midreset_frame_ok: got %0d pulses want 1", ok_cnt); end
    endtask

    task automatic test_back_to_back;
        ok_cnt = 0;
        send_frame(mkf(40'd1, 5'd0), FB, 1);
        send_frame(mkf(40'h80_0002_0002, 5'd0), FB, 8);
        A_HI = 8'h76; #1;
        n_cmp++; if (KB !== 5'h09) begin n_bad++; $display("FAIL b2b_kb: got %b want %b", KB, 5'h09); end
        n_cmp++; if (ok_cnt != 2) begin n_bad++; $display("FAIL b2b_frame_ok: got %0d pulses want 2", ok_cnt); end
        n_cmp++; if (ERR_CNT !== 4'(exp_err)) begin n_bad++; $display("FAIL b2b_err: got %0d want %0d", ERR_CNT, exp_err); end
    endtask

    task automatic test_err_saturation;
        for (int i = 0; i < 17; i++) begin
            KBD_CS = 1'b0;
            clks(6);
            KBD_CS = 1'b1;
            clks(6);
            if (i == 14) begin
                n_cmp++; if (ERR_CNT !== 4'd15) begin n_bad++; $display("FAIL err_reach15: got %0d want 15", ERR_CNT); end
            end
        end
        n_cmp++; if (ERR_CNT !== 4'd15) begin n_bad++; $display("FAIL err_saturate: got %0d want 15", ERR_CNT); end
        A_HI = 8'h76; #1;
        n_cmp++; if (KB !== 5'h09) begin n_bad++; $display("FAIL err_sat_kb: got %b want %b", KB, 5'h09); end
        n_cmp++; if (ok_wide != 0) begin n_bad++; $display("FAIL frame_ok_width: got %0d long pulses want 0", ok_wide); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_multi_key();
        test_short_frame();
`ifdef KBD_JOY_EN
        test_joy();
`else
        test_long_frame();
`endif
        test_bitcnt_saturation();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_err_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
